// File: rtl/read_spi.sv
// SPI read master: issues a 24-bit mode-0 frame {1, addr[6:0], 16'h0} and
// deserializes the 16 trailing MISO bits into rd_data with a one-cycle strobe.
module read_spi #(
    parameter int unsigned CLK_DIV_HALF = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [6:0]  rd_addr,
    input  logic        rd_req,
    output logic        busy,
    output logic [15:0] rd_data,
    output logic        rd_data_vld,
    output logic        once_end_r,
    output logic        sclk_r,
    output logic        csb_r,
    output logic        sdo_r,
    input  logic        sdi_r
);

    localparam logic [7:0] HalfLd = 8'(CLK_DIV_HALF - 1);

    typedef enum logic [1:0] {StIdle, StSetup, StShift, StGap} state_e;

    state_e      state;
    logic [7:0]  div_cnt;
    logic [4:0]  bit_cnt;
    logic [23:0] tx_shift;
    logic [15:0] rx_shift;
    logic        sdi_meta;
    logic        sdi_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sdi_meta <= 1'b0;
            sdi_sync <= 1'b0;
        end else begin
            sdi_meta <= sdi_r;
            sdi_sync <= sdi_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= StIdle;
            div_cnt     <= 8'd0;
            bit_cnt     <= 5'd0;
            tx_shift    <= 24'd0;
            rx_shift    <= 16'd0;
            rd_data     <= 16'd0;
            rd_data_vld <= 1'b0;
            once_end_r  <= 1'b0;
            sclk_r      <= 1'b0;
            csb_r       <= 1'b1;
            sdo_r       <= 1'b0;
            busy        <= 1'b0;
        end else begin
            rd_data_vld <= 1'b0;
            once_end_r  <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (rd_req) begin
                        state    <= StSetup;
                        busy     <= 1'b1;
                        csb_r    <= 1'b0;
                        tx_shift <= {1'b1, rd_addr, 16'h0000};
                        sdo_r    <= 1'b1;
                        div_cnt  <= HalfLd;
                        bit_cnt  <= 5'd0;
                    end
                end
                StSetup: begin
                    if (div_cnt == 8'd0) begin
                        state   <= StShift;
                        sclk_r  <= 1'b1;
                        div_cnt <= HalfLd;
                        bit_cnt <= 5'd23;
                    end else begin
                        div_cnt <= div_cnt - 8'd1;
                    end
                end
                StShift: begin
                    if (div_cnt != 8'd0) begin
                        div_cnt <= div_cnt - 8'd1;
                    end else if (sclk_r) begin
                        // End of high phase: falling edge moves MOSI, data bits sample MISO.
                        sclk_r   <= 1'b0;
                        tx_shift <= {tx_shift[22:0], 1'b0};
                        sdo_r    <= tx_shift[22];
                        div_cnt  <= HalfLd;
                        if (bit_cnt < 5'd16) begin
                            rx_shift <= {rx_shift[14:0], sdi_sync};
                        end
                    end else if (bit_cnt == 5'd0) begin
                        state       <= StGap;
                        csb_r       <= 1'b1;
                        rd_data_vld <= 1'b1;
                        once_end_r  <= 1'b1;
                        rd_data     <= rx_shift;
                        div_cnt     <= HalfLd;
                        bit_cnt     <= 5'd1;
                    end else begin
                        sclk_r  <= 1'b1;
                        bit_cnt <= bit_cnt - 5'd1;
                        div_cnt <= HalfLd;
                    end
                end
                StGap: begin
                    // Two half periods so the 8-bit divider covers 2H for any legal H.
                    if (div_cnt != 8'd0) begin
                        div_cnt <= div_cnt - 8'd1;
                    end else if (bit_cnt != 5'd0) begin
                        bit_cnt <= bit_cnt - 5'd1;
                        div_cnt <= HalfLd;
                    end else begin
                        state   <= StIdle;
                        busy    <= 1'b0;
                        div_cnt <= 8'd0;
                        bit_cnt <= 5'd0;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_read_spi.sv
// Bench for read_spi: H=4 and H=3 instances, each with a mode-0 device model
// and a frame monitor; expectations come from frame arithmetic in the bench.
module tb_read_spi;

    localparam int unsigned HA = 4;
    localparam int unsigned HB = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [6:0]  rd_addr[2] = '{7'd0, 7'd0};
    logic        rd_req[2] = '{1'b0, 1'b0};
    logic        busy[2];
    logic [15:0] rd_data[2];
    logic        vld[2];
    logic        once_end[2];
    logic        sclk[2];
    logic        csb[2];
    logic        sdo[2];
    logic        sdi[2] = '{1'b0, 1'b0};

    int n_err = 0;
    int n_checks = 0;
    int cyc = 0;

    int start_cyc[2] = '{0, 0};
    int start_cnt[2] = '{0, 0};
    int done_cnt[2] = '{0, 0};
    int period[2] = '{0, 0};
    int gap[2] = '{0, 0};
    int csb_run[2] = '{0, 0};
    int csb_low[2] = '{0, 0};
    int rises[2] = '{0, 0};
    int falls[2] = '{0, 0};
    int vld_n[2] = '{0, 0};
    int vld_off[2] = '{0, 0};
    int busy_off[2] = '{0, 0};
    int oe_bad[2] = '{0, 0};
    int rise_total[2] = '{0, 0};
    int stray_vld[2] = '{0, 0};
    logic [23:0] sdo_cap[2] = '{24'd0, 24'd0};
    logic [15:0] dev_word[2] = '{16'd0, 16'd0};
    logic [15:0] vld_data[2] = '{16'd0, 16'd0};
    logic        busy_p[2] = '{1'b0, 1'b0};
    logic        sclk_p[2] = '{1'b0, 1'b0};
    logic [15:0] dev_q0[$];
    logic [15:0] dev_q1[$];

    read_spi #(.CLK_DIV_HALF(HA)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr[0]), .rd_req(rd_req[0]),
        .busy(busy[0]), .rd_data(rd_data[0]), .rd_data_vld(vld[0]),
        .once_end_r(once_end[0]), .sclk_r(sclk[0]), .csb_r(csb[0]), .sdo_r(sdo[0]),
        .sdi_r(sdi[0])
    );

    read_spi #(.CLK_DIV_HALF(HB)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr[1]), .rd_req(rd_req[1]),
        .busy(busy[1]), .rd_data(rd_data[1]), .rd_data_vld(vld[1]),
        .once_end_r(once_end[1]), .sclk_r(sclk[1]), .csb_r(csb[1]), .sdo_r(sdo[1]),
        .sdi_r(sdi[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] pop_word(input int i);
        logic [15:0] w;
        w = 16'h0000;
        if (i == 0 && dev_q0.size() > 0) w = dev_q0.pop_front();
        if (i == 1 && dev_q1.size() > 0) w = dev_q1.pop_front();
        return w;
    endfunction

    task automatic push_word(input int i, input logic [15:0] w);
        if (i == 0) dev_q0.push_back(w);
        else dev_q1.push_back(w);
    endtask

    // Frame monitor and device model; device shifts its word out on sclk falls 8..23.
    task automatic mon(input int i);
        if (sclk[i] && !sclk_p[i]) rise_total[i]++;
        if (csb[i]) csb_run[i]++;
        if (busy[i] && !busy_p[i]) begin
            period[i] = cyc - start_cyc[i];
            start_cyc[i] = cyc;
            start_cnt[i]++;
            gap[i] = csb_run[i];
            csb_low[i] = 0;
            rises[i] = 0;
            falls[i] = 0;
            vld_n[i] = 0;
            vld_off[i] = 0;
            oe_bad[i] = 0;
            sdo_cap[i] = 24'd0;
            dev_word[i] = pop_word(i);
        end
        if (!csb[i]) csb_run[i] = 0;
        if (busy[i]) begin
            if (!csb[i]) csb_low[i]++;
            if (sclk[i] && !sclk_p[i]) begin
                rises[i]++;
                sdo_cap[i] = {sdo_cap[i][22:0], sdo[i]};
            end
            if (!sclk[i] && sclk_p[i] && !csb[i]) begin
                falls[i]++;
                if (falls[i] >= 8 && falls[i] < 24) sdi[i] = dev_word[i][23 - falls[i]];
            end
            if (vld[i]) begin
                vld_n[i]++;
                vld_off[i] = cyc - start_cyc[i] + 1;
                vld_data[i] = rd_data[i];
            end
        end else if (vld[i]) begin
            stray_vld[i]++;
        end
        if (once_end[i] !== vld[i]) oe_bad[i]++;
        if (!busy[i] && busy_p[i]) begin
            busy_off[i] = cyc - start_cyc[i] + 1;
            done_cnt[i]++;
        end
        busy_p[i] = busy[i];
        sclk_p[i] = sclk[i];
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    task automatic start_read(input int i, input logic [6:0] a);
        rd_addr[i] = a;
        rd_req[i] = 1'b1;
        @(posedge clk);
        #1 rd_req[i] = 1'b0;
    endtask

    task automatic wait_done(input int i, input int budget);
        int d0;
        int n;
        d0 = done_cnt[i];
        n = 0;
        while (done_cnt[i] == d0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("frame_done_in_budget", done_cnt[i] - d0, 1);
    endtask

    task automatic check_frame(input int i, input logic [6:0] a, input logic [15:0] w,
                               input int h);
        check("sdo_frame", {8'h00, sdo_cap[i]}, {8'h00, 1'b1, a, 16'h0000});
        check("sclk_rises", rises[i], 24);
        check("csb_low_cycles", csb_low[i], 49 * h);
        check("vld_count", vld_n[i], 1);
        check("vld_cycle", vld_off[i], 49 * h + 1);
        check("busy_low_cycle", busy_off[i], 51 * h + 1);
        check("rd_data_at_vld", {16'h0, vld_data[i]}, {16'h0, w});
        check("rd_data_held", {16'h0, rd_data[i]}, {16'h0, w});
        check("once_end_align", oe_bad[i], 0);
    endtask

    task automatic do_read(input int i, input logic [6:0] a, input logic [15:0] w,
                           input int h);
        push_word(i, w);
        @(negedge clk);
        #1;
        start_read(i, a);
        wait_done(i, 60 * h);
        check_frame(i, a, w, h);
    endtask

    initial begin
        int r0;
        int s0;
        logic [6:0] ra;
        logic [15:0] rw;

        #1 rst_n = 1'b0;
        #2;
        check("rst_sclk", sclk[0], 0);
        check("rst_csb", csb[0], 1);
        check("rst_sdo", sdo[0], 0);
        check("rst_busy", busy[0], 0);
        check("rst_rd_data", rd_data[0], 0);
        check("rst_vld", vld[0], 0);
        check("rst_once_end", once_end[0], 0);
        check("rst_csb_b", csb[1], 1);
        repeat (10) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        r0 = rise_total[0];
        repeat (20) @(posedge clk);
        check("idle_no_sclk", rise_total[0], r0);

        do_read(0, 7'h15, 16'hA5C3, HA);

        // Request mid-frame is ignored; next request lands on the earliest accept cycle.
        push_word(0, 16'h5A3C);
        @(negedge clk);
        #1;
        start_read(0, 7'h15);
        repeat (48) @(posedge clk);
        #1 rd_addr[0] = 7'h7F;
        rd_req[0] = 1'b1;
        @(posedge clk);
        #1 rd_req[0] = 1'b0;
        wait_done(0, 300);
        check_frame(0, 7'h15, 16'h5A3C, HA);
        push_word(0, 16'h0F0F);
        start_read(0, 7'h6C);
        wait_done(0, 300);
        check_frame(0, 7'h6C, 16'h0F0F, HA);
        check("csb_gap", gap[0], 2 * HA + 1);

        // rd_req tied high for two frames.
        push_word(0, 16'h0001);
        push_word(0, 16'h8000);
        @(negedge clk);
        #1;
        rd_addr[0] = 7'h2A;
        rd_req[0] = 1'b1;
        wait_done(0, 300);
        check("cont_data0", vld_data[0], 16'h0001);
        check("cont_vld0", vld_n[0], 1);
        s0 = start_cnt[0];
        @(negedge clk);
        #1 rd_req[0] = 1'b0;
        check("cont_restart", start_cnt[0] - s0, 1);
        check("cont_period", period[0], 51 * HA + 1);
        wait_done(0, 300);
        check_frame(0, 7'h2A, 16'h8000, HA);
        s0 = start_cnt[0];
        repeat (20) @(posedge clk);
        check("cont_stops", start_cnt[0], s0);

        // Asynchronous reset in the middle of the shift phase.
        push_word(0, 16'hBEEF);
        @(negedge clk);
        #1;
        start_read(0, 7'h33);
        repeat (98) @(posedge clk);
        #3;
        check("pre_reset_csb_low", csb[0], 0);
        rst_n = 1'b0;
        #1;
        check("abort_csb", csb[0], 1);
        check("abort_sclk", sclk[0], 0);
        check("abort_busy", busy[0], 0);
        check("abort_rd_data", rd_data[0], 0);
        @(negedge clk);
        #1;
        check("abort_no_vld", vld_n[0], 0);
        repeat (10) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        r0 = rise_total[0];
        repeat (10) @(posedge clk);
        check("post_reset_no_sclk", rise_total[0], r0);
        do_read(0, 7'h01, 16'h1234, HA);

        do_read(1, 7'h4B, 16'hFFFF, HB);
        do_read(1, 7'h12, 16'h0000, HB);

        for (int k = 0; k < 6; k++) begin
            ra = 7'($urandom_range(0, 127));
            rw = 16'($urandom);
            do_read(0, ra, rw, HA);
        end
        for (int k = 0; k < 3; k++) begin
            ra = 7'($urandom_range(0, 127));
            rw = 16'($urandom);
            do_read(1, ra, rw, HB);
        end

        check("stray_vld", stray_vld[0] + stray_vld[1], 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/read_spi.md
# read_spi

SPI read master for the HP synthesizer register interface, the read-side counterpart of the existing 24-bit SPI write path. It accepts a one-cycle read request with a 7-bit register address and issues a 24-bit mode-0 frame: a read command byte followed by 16 data clocks. It deserializes the device's MISO line into a 16-bit word and presents it with a one-cycle valid strobe. It sits beside the write engine under the HP driver and shares the device's sclk/csb/sdo pins through an external mux, which selects on `busy`.

## Interface
Parameters:
- CLK_DIV_HALF, 4, clk cycles per sclk half period (H); legal range 3..255.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- rd_addr  in  7  register address, latched on request accept
- rd_req  in  1  read request; sampled only in IDLE
- busy  out  1  high whenever state != IDLE
- rd_data  out  16  last word read; held until next completion
- rd_data_vld  out  1  one-cycle strobe, rd_data valid
- once_end_r  out  1  one-cycle strobe at frame end; coincident with rd_data_vld
- sclk_r  out  1  SPI clock, idle low
- csb_r  out  1  chip select, active low
- sdo_r  out  1  MOSI, command bits
- sdi_r  in  1  MISO from device, asynchronous to clk

## Operation
- Frame: {1'b1, rd_addr[6:0], 16'h0000}, shifted MSB first. sdo_r stays 0 through the 16 data bits.
- sdi_r passes through a 2-FF synchronizer before use.
- States:
  - IDLE: rd_req=1 latches the address, loads the shift register, and moves to SETUP.
  - SETUP: H cycles; csb_r=0, sclk_r=0, sdo_r=bit23.
  - SHIFT: 24 bit periods, each H cycles with sclk_r high followed by H cycles with sclk_r low.
    - sdo_r advances to the next bit on each falling edge.
    - After the 24th low phase, csb_r=1, rd_data_vld and once_end_r pulse, and the state moves to GAP.
  - GAP: 2H cycles with csb_r=1 and sclk_r=0, then IDLE.
- Sampling: the synchronized sdi is shifted into rd_data's shift register on the last clk of each high phase of bits 15..0, MSB first. The command-phase bits are not captured. rd_data updates in the same cycle as rd_data_vld.
- Half-period and bit counting uses an 8-bit divider counter and a 5-bit bit counter. Both reload on every state entry.
- rd_req while busy is ignored. It is neither queued nor errored.
- rd_req held high starts a new frame every time IDLE is reached.
- All outputs are registered.

## Timing
- Reset values: sclk_r=0, csb_r=1, sdo_r=0, busy=0, rd_data=16'h0000, rd_data_vld=0, once_end_r=0. The state is IDLE and the counters are 0.
- Define the rd_req accept cycle as cycle 0. Then:
  - busy=1 and csb_r=0 from cycle 1.
  - The first sclk rise is at cycle 1+H.
  - csb_r is low for 49H cycles and rises at cycle 1+49H.
  - rd_data_vld and once_end_r fire at cycle 1+49H.
  - busy falls at cycle 1+51H.
  - The earliest next accept is cycle 1+51H.
- With H=4: csb low on cycles 1..196, vld at 197, busy low at 205. The request period is 205 cycles.
- Each frame has exactly 24 sclk rising edges. sclk duty is 50%, with period 2H.
- Mid-frame reset (async): csb_r goes to 1 and sclk_r to 0 immediately. No vld is issued. rd_data returns to 0.
- rd_req and reset deassertion in the same cycle: the request is accepted only on the first clock edge after rst_n is high.

## Test plan
- Reset: assert rst_n=0 mid-idle → all outputs equal their reset values. Hold reset 10 cycles and release → no sclk activity.
- Single read, H=4, rd_addr=7'h15, device model drives 16'hA5C3 on falling edges → expected response:
  - sdo captured on rising edges = 24'h950000.
  - 24 sclk rises, csb low for exactly 196 cycles.
  - rd_data=16'hA5C3 with vld at cycle 197, busy low at 205.
- Busy rejection: rd_req pulses at cycle 50 with rd_addr=7'h7F → frame unchanged (24'h950000), single vld. A request at cycle 205 is accepted, and the csb high gap is ≥8 cycles.
- Continuous request, rd_req tied high, device returning 16'h0001 then 16'h8000 → expected response:
  - frames start every 205 cycles;
  - rd_data sequence is 0001, 8000;
  - one vld per frame.
- Reset during SHIFT, asserted at cycle 100 → csb_r=1 and sclk_r=0 asynchronously, no vld. A subsequent read of 7'h01 returning 16'h1234 completes correctly.
- H=3 build, device sdi tied 1 then tied 0 → rd_data=16'hFFFF then 16'h0000, vld at cycle 148, busy low at 154.
